// File: rtl/fp_fmt_pkg.sv
// Shared FP12/FP8 format constants and operand classification used by the
// FP8 input sanitizer and the FP12-to-FP8 output packer.
package fp_fmt_pkg;

  localparam int FP12_W     = 12;
  localparam int FP8_W      = 8;
  localparam int EXP_W      = 4;
  localparam int EXP_BIAS   = 7;
  localparam int FP12_MAN_W = 7;
  localparam int FP8_MAN_W  = 3;

  localparam logic [FP8_W-2:0] FP8_MAX_MAG = 7'b1110111;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 4'hF;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORM,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  function automatic fp_class_e fp12_classify(input logic [EXP_W-1:0]      i_e,
                                              input logic [FP12_MAN_W-1:0] i_m);
    if (i_e == '0) return (i_m == '0) ? ZERO : SUBNORM;
    if (i_e == EXP_SPECIAL) return (i_m == '0) ? INF : NAN;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp12_to_fp8_round.sv
// Combinational FP12 -> FP8 E4M3 narrowing: round-to-nearest-even (or truncate),
// saturation to max finite, and flush-to-zero of subnormals and NaNs.
module fp12_to_fp8_round
  import fp_fmt_pkg::*;
#(
  parameter bit RNE_EN = 1'b1
) (
  input  fp_class_e             i_cls,
  input  logic                  i_sign,
  input  logic [EXP_W-1:0]      i_exp,
  input  logic [FP12_MAN_W-1:0] i_man,
  output logic [FP8_W-1:0]      o_fp8,
  output logic                  o_sat,
  output logic                  o_flush
);

  localparam int MAG_W = EXP_W + FP8_MAN_W;

  logic [FP8_MAN_W-1:0] w_keep;
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_round_up;
  logic [MAG_W-1:0]     w_mag;

  assign w_keep     = i_man[FP12_MAN_W-1 -: FP8_MAN_W];
  assign w_guard    = i_man[FP12_MAN_W-FP8_MAN_W-1];
  assign w_sticky   = |i_man[FP12_MAN_W-FP8_MAN_W-2:0];
  assign w_round_up = RNE_EN && w_guard && (w_sticky || w_keep[0]);

  // A mantissa carry ripples into the exponent field through the shared add.
  assign w_mag = {i_exp, w_keep} + MAG_W'(w_round_up);

  always_comb begin
    o_fp8   = '0;
    o_sat   = 1'b0;
    o_flush = 1'b0;
    case (i_cls)
      NORMAL: begin
        if (w_mag[MAG_W-1 -: EXP_W] == EXP_SPECIAL) begin
          o_fp8 = {i_sign, FP8_MAX_MAG};
          o_sat = 1'b1;
        end else begin
          o_fp8 = {i_sign, w_mag};
        end
      end
      INF: begin
        o_fp8 = {i_sign, FP8_MAX_MAG};
        o_sat = 1'b1;
      end
      NAN, SUBNORM: begin
        o_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fp12_to_fp8_packer.sv
// Two-stage valid/ready pipeline narrowing FP12 MAC results to FP8 E4M3,
// with saturating debug counters for saturated and flushed results.
module fp12_to_fp8_packer
  import fp_fmt_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit RNE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP12_W-1:0] fp12_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP8_W-1:0]  fp8_out,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sat_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic [EXP_W-1:0]      r_s1_exp;
  logic [FP12_MAN_W-1:0] r_s1_man;
  fp_class_e             r_s1_cls;

  logic                  r_s2_valid;
  logic                  r_s2_sat;
  logic                  r_s2_flush;
  logic [FP8_W-1:0]      r_fp8;

  logic [CNT_W-1:0]      r_sat_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic                  w_s1_en;
  logic                  w_s2_en;
  logic                  w_out_fire;
  logic [EXP_W-1:0]      w_in_exp;
  logic [FP12_MAN_W-1:0] w_in_man;
  logic [FP8_W-1:0]      w_fp8;
  logic                  w_sat;
  logic                  w_flush;

  assign w_s2_en    = !r_s2_valid || out_ready;
  assign w_s1_en    = !r_s1_valid || w_s2_en;
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_in_exp   = fp12_in[FP12_W-2 -: EXP_W];
  assign w_in_man   = fp12_in[FP12_MAN_W-1:0];

  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_valid;
  assign fp8_out   = r_fp8;
  assign sat_cnt   = r_sat_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_man   <= '0;
      r_s1_cls   <= ZERO;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= fp12_in[FP12_W-1];
        r_s1_exp  <= w_in_exp;
        r_s1_man  <= w_in_man;
        r_s1_cls  <= fp12_classify(w_in_exp, w_in_man);
      end
    end
  end

  fp12_to_fp8_round #(
    .RNE_EN (RNE_EN)
  ) u_round (
    .i_cls   (r_s1_cls),
    .i_sign  (r_s1_sign),
    .i_exp   (r_s1_exp),
    .i_man   (r_s1_man),
    .o_fp8   (w_fp8),
    .o_sat   (w_sat),
    .o_flush (w_flush)
  );

  // fp8_out only reloads when a new result moves in, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sat   <= 1'b0;
      r_s2_flush <= 1'b0;
      r_fp8      <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_fp8      <= w_fp8;
        r_s2_sat   <= w_sat;
        r_s2_flush <= w_flush;
      end
    end
  end

  // Counters tick on delivered results only and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt   <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_sat_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_fire && r_s2_sat && (r_sat_cnt != '1)) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
      if (w_out_fire && r_s2_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp12_to_fp8_packer.sv
// Self-checking bench for fp12_to_fp8_packer: directed vectors, an arithmetic
// reference model with an in-flight queue, and a wide plus a 2-bit-counter instance.
module tb_fp12_to_fp8_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [11:0] fp12_in;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  fp8_out;
  logic [15:0] sat16;
  logic [15:0] flush16;

  logic        in_ready2;
  logic        out_valid2;
  logic [7:0]  fp8_out2;
  logic [1:0]  sat2;
  logic [1:0]  flush2;

  always #5 clk = ~clk;

  fp12_to_fp8_packer #(.CNT_W(16), .RNE_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp12_in   (fp12_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp8_out   (fp8_out),
    .cnt_clr   (cnt_clr),
    .sat_cnt   (sat16),
    .flush_cnt (flush16)
  );

  fp12_to_fp8_packer #(.CNT_W(2), .RNE_EN(1'b1)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .fp12_in   (fp12_in),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .fp8_out   (fp8_out2),
    .cnt_clr   (cnt_clr),
    .sat_cnt   (sat2),
    .flush_cnt (flush2)
  );

  typedef struct {
    logic [7:0] fp8;
    bit         sat;
    bit         flush;
    logic [7:0] lit;
    bit         hasLit;
    int         cyc;
  } item_t;

  item_t      q[$];
  int         nVectors = 0;
  int         nMiscompares = 0;
  int         cyc = 0;
  longint     satCount = 0;
  longint     flushCount = 0;
  logic [7:0] litNext = 8'h00;
  bit         hasLitNext = 1'b0;
  bit         prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nVectors++;
    if (act !== expv) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference narrowing computed from magnitudes: value = exp*8 + kept mantissa.
  function automatic void fp8Model(input logic [11:0] x, output logic [7:0] y,
                                   output bit sat, output bit flush);
    int e, m, kq, r, mag;
    bit up;
    e = int'(x[10:7]);
    m = int'(x[6:0]);
    y = 8'h00;
    sat = 1'b0;
    flush = 1'b0;
    if (e == 15) begin
      if (m == 0) begin
        y = {x[11], 7'h77};
        sat = 1'b1;
      end else begin
        flush = 1'b1;
      end
    end else if (e == 0) begin
      flush = (m != 0);
    end else begin
      kq = m / 16;
      r = m % 16;
      up = (r > 8) || (r == 8 && (kq % 2) == 1);
      mag = e * 8 + kq + (up ? 1 : 0);
      if (mag >= 120) begin
        y = {x[11], 7'h77};
        sat = 1'b1;
      end else begin
        y = {x[11], 7'(mag)};
      end
    end
  endfunction

  function automatic longint capCnt(input longint c, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  // Compare process: at every falling edge check the DUTs against the model,
  // then account for the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    item_t it;
    logic [7:0] y;
    bit s, f, expOv, expRdy;
    cyc++;
    if (!rst_n) begin
      q.delete();
      satCount = 0;
      flushCount = 0;
      prevStall = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_fp8_out", 32'(fp8_out), 0);
      checkOutput("rst_sat_cnt", 32'(sat16), 0);
      checkOutput("rst_flush_cnt", 32'(flush16), 0);
      checkOutput("rst_sat_cnt2", 32'(sat2), 0);
    end else begin
      expOv = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      expRdy = !(q.size() >= 2 && !out_ready);
      checkOutput("out_valid", 32'(out_valid), 32'(expOv));
      checkOutput("out_valid2", 32'(out_valid2), 32'(expOv));
      checkOutput("in_ready", 32'(in_ready), 32'(expRdy));
      checkOutput("in_ready2", 32'(in_ready2), 32'(expRdy));
      checkOutput("sat_cnt", 32'(sat16), 32'(capCnt(satCount, 16)));
      checkOutput("flush_cnt", 32'(flush16), 32'(capCnt(flushCount, 16)));
      checkOutput("sat_cnt2", 32'(sat2), 32'(capCnt(satCount, 2)));
      checkOutput("flush_cnt2", 32'(flush2), 32'(capCnt(flushCount, 2)));
      if (prevStall) checkOutput("stall_hold", 32'(fp8_out), 32'(prevData));
      if (out_valid && out_ready && q.size() > 0) begin
        it = q.pop_front();
        checkOutput("fp8_out", 32'(fp8_out), 32'(it.fp8));
        checkOutput("fp8_out2", 32'(fp8_out2), 32'(it.fp8));
        if (it.hasLit) checkOutput("fp8_literal", 32'(fp8_out), 32'(it.lit));
        if (it.sat) satCount++;
        if (it.flush) flushCount++;
      end
      if (cnt_clr) begin
        satCount = 0;
        flushCount = 0;
      end
      prevStall = out_valid && !out_ready;
      prevData = fp8_out;
      if (in_valid && in_ready) begin
        fp8Model(fp12_in, y, s, f);
        it.fp8 = y;
        it.sat = s;
        it.flush = f;
        it.lit = litNext;
        it.hasLit = hasLitNext;
        it.cyc = cyc;
        q.push_back(it);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [11:0] d, input logic [7:0] lit, input bit hasLit);
    bit acc;
    int budget;
    fp12_in = d;
    litNext = lit;
    hasLitNext = hasLit;
    in_valid = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    hasLitNext = 1'b0;
    checkOutput("accepted", 32'(acc), 1);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    fp12_in = 12'h000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: result visible two cycles after the accepting cycle.
    fp12_in = 12'h3C0;
    litNext = 8'h3C;
    hasLitNext = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("lat_accept", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    hasLitNext = 1'b0;
    @(negedge clk);
    checkOutput("lat_cycle1_valid", 32'(out_valid), 0);
    @(negedge clk);
    checkOutput("lat_cycle2_valid", 32'(out_valid), 1);
    checkOutput("lat_cycle2_data", 32'(fp8_out), 'h3C);
    checkOutput("lat_no_count", 32'(sat16), 0);
    @(posedge clk);
    #1;

    // Round-to-nearest-even ties and mantissa carry.
    applyStimulus(12'h388, 8'h38, 1'b1);
    applyStimulus(12'h398, 8'h3A, 1'b1);
    applyStimulus(12'h6F8, 8'h70, 1'b1);
    applyStimulus(12'h3D9, 8'h3E, 1'b1);
    waitCycles(4);

    // Saturation from rounding overflow and from infinity.
    applyStimulus(12'h778, 8'h77, 1'b1);
    waitCycles(4);
    @(negedge clk);
    checkOutput("sat_after_778", 32'(sat16), 1);
    @(posedge clk);
    #1;
    applyStimulus(12'hF80, 8'hF7, 1'b1);
    waitCycles(4);
    @(negedge clk);
    checkOutput("sat_after_neg_inf", 32'(sat16), 2);
    @(posedge clk);
    #1;

    // NaN, subnormal and negative zero.
    applyStimulus(12'h7C1, 8'h00, 1'b1);
    applyStimulus(12'h005, 8'h00, 1'b1);
    applyStimulus(12'h800, 8'h00, 1'b1);
    waitCycles(4);
    @(negedge clk);
    checkOutput("flush_after_specials", 32'(flush16), 2);
    checkOutput("sat_after_specials", 32'(sat16), 2);
    @(posedge clk);
    #1;

    // Backpressure: five stalled cycles, then drain in order.
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(12'h3C0, 8'h3C, 1'b1);
        applyStimulus(12'h398, 8'h3A, 1'b1);
        applyStimulus(12'h6F8, 8'h70, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_low", 32'(in_ready), 0);
        checkOutput("bp_hold_data", 32'(fp8_out), 'h3C);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitCycles(6);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) applyStimulus(12'h778, 8'h77, 1'b1);
    waitCycles(4);
    @(negedge clk);
    checkOutput("sat16_after_7", 32'(sat16), 7);
    checkOutput("sat2_stuck", 32'(sat2), 3);
    @(posedge clk);
    #1;

    // Clear wins over a same-cycle saturating handshake.
    out_ready = 1'b0;
    applyStimulus(12'hF80, 8'hF7, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("clr_setup_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_sat16", 32'(sat16), 0);
    checkOutput("clr_sat2", 32'(sat2), 0);
    @(posedge clk);
    #1;

    // Reset with both stages full discards in-flight data.
    applyStimulus(12'h778, 8'h77, 1'b1);
    waitCycles(4);
    out_ready = 1'b0;
    applyStimulus(12'h3C0, 8'h3C, 1'b1);
    applyStimulus(12'h398, 8'h3A, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_fp8_out", 32'(fp8_out), 0);
    checkOutput("midrst_sat16", 32'(sat16), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_stale_output", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(12'h3C0, 8'h3C, 1'b1);
    waitCycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
